uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered UART transmitter: bus-side producer writes bytes into an internal FIFO; block serialises them LSB-first as 8N1 frames on tx_data at clk_per_bit clocks per bit.
- Counterpart of uart_rx on the same serial link; frames are directly decodable by uart_rx with an identical clk_per_bit.
- Sits between the system bus write path and the UART pin; decouples bursty bus writes from the slow line rate.

Parameters:
- clk_per_bit, 87, clocks per serial bit (10 MHz / 115200); legal range 4..65535.
- fifo_addr_w, 3, FIFO depth = 2**fifo_addr_w entries (default 8).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  push wr_data into FIFO this cycle.
- wr_data  input  8  byte to transmit.
- full  output  1  FIFO holds 2**fifo_addr_w entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  fifo_addr_w+1  current FIFO occupancy.
- overflow  output  1  sticky: a write was attempted while full.
- tx_data  output  1  serial line, idle high.
- tx_busy  output  1  high in any state except IDLE.
- tx_done  output  1  one-cycle pulse on the last clock of each stop bit.

Behaviour:
- Reset, asynchronous: tx_data=1, tx_busy=0, tx_done=0, overflow=0, count=0, empty=1, full=0, state=IDLE, bit timer=0, FIFO pointers=0.
- Reset asserted mid-frame: line returns high immediately; FIFO contents discarded; no tx_done pulse.
- FIFO:
  - Write accepted when wr_en=1 and the registered full=0.
  - A write while full is dropped and sets overflow, which stays high until reset.
  - Write and pop in the same cycle: both occur; count unchanged. This is legal even when full, because full is sampled before the pop.
  - Pointers wrap modulo depth; count is a separate up/down counter.
  - full and empty are registered and derived from count.
- States:
  - IDLE -> START: when empty=0, pop the head into the 8-bit shift register, drive tx_data=0, timer=0.
  - START -> DATA: after clk_per_bit clocks.
  - DATA: tx_data=shift[0]; shift right every clk_per_bit clocks; bit index 0..7. After bit 7 completes -> STOP (or PARITY, see feature).
  - STOP: tx_data=1 for clk_per_bit clocks. On its last clock, tx_done=1.
    - If empty=0: pop and go to START; frames are back-to-back with no idle gap.
    - Else: go to IDLE.
- Bit timer counts 0..clk_per_bit-1 and wraps; every bit lasts exactly clk_per_bit clocks.
- Latency: write in cycle N with an empty FIFO and IDLE state -> empty=0 at N+1 -> pop at N+1 -> tx_data falls at N+2.
- Frame length: 10*clk_per_bit clocks (11 with the feature enabled).
- tx_busy is 1 from the cycle tx_data first falls until IDLE is re-entered.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - tx_data = XOR of the 8 data bits (even parity) for clk_per_bit clocks.
  - Frame is 11 bits.
- Undefined: no PARITY state; 8N1 only; parity logic absent.

Test Plan:
- Reset held, wr_en=1 wr_data=8'h55 -> no write accepted; tx_data=1, count=0, empty=1 throughout.
- Write 8'hAB once (clk_per_bit=87, 100 ns clock):
  - tx_data falls 2 clocks after the write.
  - Line carries start 0, then bits 1,1,0,1,0,1,0,1, then stop 1; each bit is 8700 ns.
  - tx_done pulses once, 870 clocks after the fall.
  - tx_busy drops the next cycle.
- Loopback into uart_rx (same clk_per_bit): write 8'h3F, 8'hA5, 8'h00 back-to-back -> uart_rx reports the same three bytes in order; no idle gap between frames; three tx_done pulses 870 clocks apart.
- Fill while transmitting: 10 writes in consecutive cycles, depth 8:
  - First byte is popped immediately; the next 8 fill the FIFO; full=1.
  - The 10th write sets overflow=1.
  - Exactly 9 frames are sent; overflow stays 1 until reset.
- Simultaneous push/pop: FIFO full, wr_en=1 on the STOP-last-clock pop cycle -> write accepted, count stays 8, overflow stays 0.
- Mid-frame reset at data bit 3 -> tx_data=1 within the same cycle; count=0; no tx_done pulse.
- With UART_TX_PARITY_EN, write 8'h07 -> parity bit=1 before the stop bit; frame is 11 bits; tx_done arrives 957 clocks after the fall.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo #(
  parameter int clk_per_bit = 87,
  parameter int fifo_addr_w = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [fifo_addr_w:0]   count,
  output logic                   overflow,
  output logic                   tx_data,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic [2:0]             fsm_state
);

  localparam int depth = 1 << fifo_addr_w;
  localparam int tw = $clog2(clk_per_bit);
  localparam logic [tw-1:0] timer_last_c = tw'(clk_per_bit - 1);
  localparam logic [tw-1:0] timer_prev_c = tw'(clk_per_bit - 2);
  localparam logic [tw-1:0] timer_one_c = tw'(1);
  localparam logic [fifo_addr_w-1:0] ptr_one_c = {{(fifo_addr_w-1){1'b0}}, 1'b1};
  localparam logic [fifo_addr_w:0] cnt_one_c = {{fifo_addr_w{1'b0}}, 1'b1};
  localparam logic [fifo_addr_w:0] depth_c = {1'b1, {fifo_addr_w{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t                 state;
  logic [tw-1:0]          timer;
  logic [2:0]             bit_idx;
  logic [7:0]             shift;
  logic [7:0]             mem [depth];
  logic [fifo_addr_w-1:0] wr_ptr;
  logic [fifo_addr_w-1:0] rd_ptr;
  logic [fifo_addr_w:0]   count_nxt;
  logic                   timer_last;
  logic                   pop;
  logic                   push;
`ifdef UART_TX_PARITY_EN
  logic                   parity;
`endif

  assign fsm_state = state;

  // Write handshake: a byte is taken when wr_en is high and either full is low
  // or the serialiser pops in that same cycle; any other wr_en is dropped and
  // latches overflow. There is no back-pressure beyond full.
  assign timer_last = (timer == timer_last_c);
  assign pop  = !empty && ((state == S_IDLE) || (state == S_STOP && timer_last));
  assign push = wr_en && (!full || pop);

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + cnt_one_c;
    else if (!push && pop)
      count_nxt = count - cnt_one_c;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + ptr_one_c;
      if (pop)
        rd_ptr <= rd_ptr + ptr_one_c;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == depth_c);
      if (wr_en && !push)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_data <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      // Registered one clock early so the pulse lands on the stop bit's last clock.
      tx_done <= (state == S_STOP) && (timer == timer_prev_c);
      case (state)
        S_IDLE: begin
          if (pop) begin
            shift   <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            parity  <= ^mem[rd_ptr];
`endif
            tx_data <= 1'b0;
            tx_busy <= 1'b1;
            timer   <= '0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (timer_last) begin
            timer   <= '0;
            bit_idx <= '0;
            tx_data <= shift[0];
            state   <= S_DATA;
          end else begin
            timer <= timer + timer_one_c;
          end
        end
        S_DATA: begin
          if (timer_last) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_data <= parity;
              state   <= S_PARITY;
`else
              tx_data <= 1'b1;
              state   <= S_STOP;
`endif
            end else begin
              shift   <= shift >> 1;
              tx_data <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer + timer_one_c;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (timer_last) begin
            timer   <= '0;
            tx_data <= 1'b1;
            state   <= S_STOP;
          end else begin
            timer <= timer + timer_one_c;
          end
        end
`endif
        S_STOP: begin
          if (timer_last) begin
            timer <= '0;
            if (pop) begin
              // Back-to-back frame: next start bit follows with no idle gap.
              shift   <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
              parity  <= ^mem[rd_ptr];
`endif
              tx_data <= 1'b0;
              state   <= S_START;
            end else begin
              tx_busy <= 1'b0;
              state   <= S_IDLE;
            end
          end else begin
            timer <= timer + timer_one_c;
          end
        end
        default: begin
          state   <= S_IDLE;
          tx_data <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: latency, frame timing, FIFO fill/overflow,
// push/pop on the stop-bit pop cycle, mid-frame reset; a line decoder checks bytes.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CPB = 87;
  localparam int AW = 3;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          tx_data;
  logic          tx_busy;
  logic          tx_done;
  logic [2:0]    fsm_state;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int rst_gen = 0;
  logic [7:0] exp_q[$];
  int done_q[$];

  uart_tx_fifo #(.clk_per_bit(CPB), .fifo_addr_w(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #50 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    cyc++;
    if (tx_done)
      done_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // scoreboard: serial decoder sampling mid-bit, compared against exp_q
  int         m_gen;
  logic [7:0] m_byte;
  logic       m_start;
  logic       m_stop;
  logic       m_par;

  initial begin
    m_par = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && tx_data === 1'b0) begin
        m_gen = rst_gen;
        repeat (CPB / 2) @(negedge clk);
        m_start = tx_data;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          m_byte[i] = tx_data;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        m_par = tx_data;
`endif
        repeat (CPB) @(negedge clk);
        m_stop = tx_data;
        if (m_gen == rst_gen) begin
          check("start_bit", 32'(m_start), 32'd0);
          check("stop_bit", 32'(m_stop), 32'd1);
`ifdef UART_TX_PARITY_EN
          check("parity_bit", 32'(m_par), 32'(^m_byte));
`endif
          check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0)
            check("rx_byte", 32'(m_byte), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic write_burst(input logic [7:0] b[$], input int n_expect);
    for (int i = 0; i < b.size(); i++) begin
      wr_en = 1'b1;
      wr_data = b[i];
      if (i < n_expect)
        exp_q.push_back(b[i]);
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < 12 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, 32'(tx_busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rst_gen++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  int dq0;
  int n;
  logic [7:0] bytes[$];

  initial begin
    // reset held with a write pending: nothing accepted
    reset = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h55;
    repeat (4) begin
      @(negedge clk);
      check("rst_tx_data", 32'(tx_data), 32'd1);
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
    end
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    wr_en = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_count", 32'(count), 32'd0);

    // single byte 0xAB: latency and frame length
    dq0 = done_q.size();
    bytes = '{8'hAB};
    write_burst(bytes, 1);
    check("lat_line_high", 32'(tx_data), 32'd1);
    check("lat_not_empty", 32'(empty), 32'd0);
    check("lat_count1", 32'(count), 32'd1);
    @(negedge clk);
    check("lat_fall", 32'(tx_data), 32'd0);
    check("lat_busy", 32'(tx_busy), 32'd1);
    check("lat_popped", 32'(count), 32'd0);
    repeat (FRAME - 2) @(negedge clk);
    check("done_not_early", 32'(tx_done), 32'd0);
    @(negedge clk);
    check("done_on_time", 32'(tx_done), 32'd1);
    check("busy_at_done", 32'(tx_busy), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(tx_done), 32'd0);
    check("busy_drop", 32'(tx_busy), 32'd0);
    check("line_idle", 32'(tx_data), 32'd1);
    wait_idle("single");
    check("single_done_cnt", 32'(done_q.size() - dq0), 32'd1);

    // three back-to-back frames, no idle gap
    dq0 = done_q.size();
    bytes = '{8'h3F, 8'hA5, 8'h00};
    write_burst(bytes, 3);
    wait_idle("b2b");
    check("b2b_done_cnt", 32'(done_q.size() - dq0), 32'd3);
    if (done_q.size() - dq0 == 3) begin
      check("b2b_gap1", 32'(done_q[dq0 + 1] - done_q[dq0]), 32'(FRAME));
      check("b2b_gap2", 32'(done_q[dq0 + 2] - done_q[dq0 + 1]), 32'(FRAME));
    end

    // ten consecutive writes: one popped, eight stored, tenth dropped
    dq0 = done_q.size();
    bytes = {};
    for (int i = 0; i < 10; i++)
      bytes.push_back(8'h10 + 8'(i));
    write_burst(bytes, 9);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd8);
    check("fill_overflow", 32'(overflow), 32'd1);
    wait_idle("fill");
    check("fill_frames", 32'(done_q.size() - dq0), 32'd9);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("fill_empty", 32'(empty), 32'd1);
    check("fill_count0", 32'(count), 32'd0);

    // write on the stop-bit pop cycle while full
    do_reset();
    check("ovf_cleared", 32'(overflow), 32'd0);
    bytes = {};
    for (int i = 0; i < 9; i++)
      bytes.push_back(8'h60 + 8'(i));
    write_burst(bytes, 9);
    check("pp_full", 32'(full), 32'd1);
    n = 0;
    while (!tx_done && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("pp_done_seen", 32'(tx_done), 32'd1);
    wr_en = 1'b1;
    wr_data = 8'hEE;
    exp_q.push_back(8'hEE);
    @(negedge clk);
    wr_en = 1'b0;
    check("pp_count", 32'(count), 32'd8);
    check("pp_still_full", 32'(full), 32'd1);
    check("pp_no_overflow", 32'(overflow), 32'd0);
    check("pp_next_start", 32'(tx_data), 32'd0);
    wait_idle("pushpop");

    // reset during data bit 3 of 0xC3 with 0x5A still queued
    bytes = '{8'hC3, 8'h5A};
    write_burst(bytes, 0);
    check("mr_fall", 32'(tx_data), 32'd0);
    check("mr_queued", 32'(count), 32'd1);
    repeat (4 * CPB + 10) @(negedge clk);
    check("mr_bit3_low", 32'(tx_data), 32'd0);
    dq0 = done_q.size();
    #10;
    reset = 1'b1;
    rst_gen++;
    #1;
    check("mr_line_high", 32'(tx_data), 32'd1);
    check("mr_count0", 32'(count), 32'd0);
    check("mr_empty", 32'(empty), 32'd1);
    check("mr_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (FRAME + 100) @(negedge clk);
    check("mr_no_done", 32'(done_q.size() - dq0), 32'd0);
    check("mr_stays_idle", 32'(tx_data), 32'd1);

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones: parity bit is 1, frame is 11 bits
    bytes = '{8'h07};
    write_burst(bytes, 1);
    @(negedge clk);
    check("par_fall", 32'(tx_data), 32'd0);
    repeat (9 * CPB + CPB / 2) @(negedge clk);
    check("par_bit", 32'(tx_data), 32'd1);
    repeat (FRAME - 1 - (9 * CPB + CPB / 2)) @(negedge clk);
    check("par_done_on_time", 32'(tx_done), 32'd1);
    wait_idle("parity");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
